alu_commit_psr: RTL and testbench
=================================

Name: alu_commit_psr

Overview:
- Commit stage directly downstream of the ALU; one pipeline register between ALU outputs and register-file write port.
- Captures result S, flags CLFZN and destination register.
- Writes result back and merges flags into the processor status register (PSR) under a per-instruction-class mask.
- Evaluates CR16 branch conditions against the committed PSR; provides forwarding and a 16-bit retired-instruction counter.

Parameters:
- DATA_W, 16, result/data width.
- REG_AW, 4, register-file address width (16 registers).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  ALU result valid this cycle.
- in_ready  out  1  stage can accept; = !stg_valid | !stall.
- in_opcode  in  4  instruction opcode, same encoding as ALU.
- in_opext  in  4  opcode extension, same encoding as ALU.
- in_rdest  in  REG_AW  destination register.
- in_wb_en  in  1  instruction writes rdest.
- in_result  in  DATA_W  ALU S.
- in_clfzn  in  5  ALU flags {C,L,F,Z,N}, bit4 = C … bit0 = N.
- stall  in  1  downstream hold; blocks commit.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_AW  write address.
- rf_wdata  out  DATA_W  write data.
- fwd_valid  out  1  stage holds a pending register write.
- fwd_reg  out  REG_AW  pending destination.
- fwd_data  out  DATA_W  pending data.
- psr_we  in  1  software PSR load (LPR).
- psr_wdata  in  5  value for software load.
- psr  out  5  committed flags {C,L,F,Z,N}.
- cond  in  4  branch condition code.
- cond_true  out  1  condition evaluates true on psr.
- cond_ok  out  1  no pending flag update; cond_true is trustworthy.
- retired  out  CNT_W  committed-instruction count.

Behaviour:
- Reset: stg_valid=0, psr=0, retired=0; therefore rf_we=0, fwd_valid=0, in_ready=1, cond_ok=1. Reset mid-stall discards the held instruction with no write.
- Capture: on an edge with in_valid & in_ready, load the stage register (opcode, opext, rdest, wb_en, result, clfzn) and set stg_valid=1.
- If in_ready & !in_valid on an edge, stg_valid=0 afterwards.
- Commit: when stg_valid & !stall, drive outputs combinationally from the stage register:
  - rf_we = stg_wb_en, rf_waddr = stg_rdest, rf_wdata = stg_result.
  - On the same edge: PSR merge; retired += 1, wrapping 0xFFFF→0.
- Stall: held entry keeps rf_we=0, PSR and retired unchanged.
- Latency: ALU output to rf write = 1 cycle without stall. Throughput 1/cycle; capture and commit may occur on the same edge.
- Flag mask (decoded from stage opcode/opext):
  - ADD 0000_0101, ADDU 0000_0110, SUB 0000_1001, ADDI 0101_x, ADDUI 0110_x, SUBI 1001_x → update C and F only.
  - CMP 0011_x, CMPI 1011_x → update L, Z, N only.
  - All others → no update.
  - psr_next = (psr & ~mask) | (stg_clfzn & mask).
- psr_we priority: a software load overrides a commit merge on the same edge (psr=psr_wdata). The instruction still retires and writes the register file.
- fwd_valid = stg_valid & stg_wb_en, independent of stall.
- cond_ok = !(stg_valid & mask!=0).
- cond_true, combinational on psr (C,L,F,Z,N):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 HI L; 5 LS !L; 6 GT N; 7 LE !N
  - 8 FS F; 9 FC !F
  - 10 LO !L&!Z; 11 HS L|Z
  - 12 LT !N&!Z; 13 GE N|Z
  - 14 UC 1; 15 never 0

Decomposition:
- Shared package:
  - opcode/opext constants (ADD, ADDI, SUB, CMP, CMPI, ...).
  - flag bit indices (C=4, L=3, F=2, Z=1, N=0).
  - 4-bit condition-code constants (EQ…UC).
  - flag-mask function.
- One natural sub-module: cond_eval (cond, psr → cond_true), reusable by fetch/branch unit.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 → psr=00000, retired=0, rf_we=0, in_ready=1.
- ADD, rdest=3, result=0x0001, clfzn=10100, no stall → next cycle rf_we=1, waddr=3, wdata=0x0001; following edge psr=10100, retired=1.
- CMP, clfzn=01011 after psr=10100 → psr=11111 (C,F kept). cond=EQ → 1, LT → 0, GE → 1. cond_ok=0 while CMP held in stage.
- Stall: hold stall=1 for 3 cycles with an AND held and in_valid=1 → in_ready=0, rf_we=0, fwd_valid=1, fwd_data stable. Release → one commit, then next instruction captured with no loss or duplication.
- Same-edge psr_we=1, psr_wdata=00001 with ADDU commit, clfzn=10100 → psr=00001, rf write still occurs, retired increments.
- Counter wrap: preload via 0xFFFF commits (or force) → next commit gives retired=0x0000.

Source files
------------

// File: rtl/alu_commit_psr_pkg.sv
// alu_commit_psr_pkg: opcode, flag and condition encodings shared by the commit stage and branch logic
package alu_commit_psr_pkg;
  localparam logic [3:0] OP_RR    = 4'b0000;
  localparam logic [3:0] OP_CMP   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ADDUI = 4'b0110;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_ADDU = 4'b0110;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam int F_C = 4;
  localparam int F_L = 3;
  localparam int F_F = 2;
  localparam int F_Z = 1;
  localparam int F_N = 0;
  localparam logic [4:0] M_CF  = 5'b10100;
  localparam logic [4:0] M_LZN = 5'b01011;
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;
  function automatic logic [4:0] flag_mask(input logic [3:0] op, input logic [3:0] ext);
    logic cf;
    cf = op == OP_ADDI || op == OP_ADDUI || op == OP_SUBI ||
         (op == OP_RR && (ext == EXT_ADD || ext == EXT_ADDU || ext == EXT_SUB));
    return cf ? M_CF : (op == OP_CMP || op == OP_CMPI) ? M_LZN : 5'b00000;
  endfunction
endpackage

// File: rtl/alu_commit_psr_if.sv
// alu_commit_psr_if: ALU result bus into the commit stage
interface alu_commit_psr_if #(parameter int DATA_W = 16, parameter int REG_AW = 4);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_opcode;
  logic [3:0]        in_opext;
  logic [REG_AW-1:0] in_rdest;
  logic              in_wb_en;
  logic [DATA_W-1:0] in_result;
  logic [4:0]        in_clfzn;
  modport master (output in_valid, in_opcode, in_opext, in_rdest, in_wb_en, in_result, in_clfzn, input in_ready);
  modport slave (input in_valid, in_opcode, in_opext, in_rdest, in_wb_en, in_result, in_clfzn, output in_ready);
endinterface

// File: rtl/alu_commit_psr_cond_eval.sv
// alu_commit_psr_cond_eval: CR16 branch condition evaluation on {C,L,F,Z,N}
module alu_commit_psr_cond_eval import alu_commit_psr_pkg::*; (
  input  logic [3:0] cond,
  input  logic [4:0] psr,
  output logic       cond_true
);
  logic c, l, f, z, n;
  logic [15:0] t;
  assign {c, l, f, z, n} = {psr[F_C], psr[F_L], psr[F_F], psr[F_Z], psr[F_N]};
  // bit i of t is the outcome of condition code i
  assign t = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f, !n, n, !l, l, !c, c, !z, z};
  assign cond_true = t[cond];
endmodule

// File: rtl/alu_commit_psr.sv
// alu_commit_psr: ALU commit register with register-file writeback, PSR merge, branch conditions and retire count
module alu_commit_psr import alu_commit_psr_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_commit_psr_if.slave   bus,
  input  logic              stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  input  logic              psr_we,
  input  logic [4:0]        psr_wdata,
  output logic [4:0]        psr,
  input  logic [3:0]        cond,
  output logic              cond_true,
  output logic              cond_ok,
  output logic [CNT_W-1:0]  retired
);
  logic              stg_valid, stg_wb_en, commit;
  logic [3:0]        stg_opcode, stg_opext;
  logic [REG_AW-1:0] stg_rdest;
  logic [DATA_W-1:0] stg_result;
  logic [4:0]        stg_clfzn, mask;
  assign mask = flag_mask(stg_opcode, stg_opext);
  assign commit = stg_valid & !stall;
  assign bus.in_ready = !stg_valid | !stall;
  assign rf_we = commit & stg_wb_en;
  assign rf_waddr = stg_rdest;
  assign rf_wdata = stg_result;
  assign fwd_valid = stg_valid & stg_wb_en;
  assign fwd_reg = stg_rdest;
  assign fwd_data = stg_result;
  assign cond_ok = !(stg_valid && mask != 5'b00000);
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid <= 1'b0;
      psr <= 5'b00000;
      retired <= '0;
    end else begin
      if (bus.in_ready) stg_valid <= bus.in_valid;
      if (bus.in_ready && bus.in_valid) begin
        stg_opcode <= bus.in_opcode;
        stg_opext <= bus.in_opext;
        stg_rdest <= bus.in_rdest;
        stg_wb_en <= bus.in_wb_en;
        stg_result <= bus.in_result;
        stg_clfzn <= bus.in_clfzn;
      end
      // a software PSR load wins over the merge of an instruction committing on the same edge
      psr <= psr_we ? psr_wdata : commit ? (psr & ~mask) | (stg_clfzn & mask) : psr;
      if (commit) retired <= retired + 1'b1;
    end
  end
  alu_commit_psr_cond_eval u_cond (.cond(cond), .psr(psr), .cond_true(cond_true));
endmodule

// File: tb/tb_alu_commit_psr.sv
// tb_alu_commit_psr: directed vectors with hand-computed expectations for the ALU commit stage
module tb_alu_commit_psr;
  logic clk = 0, reset, stall, psr_we, rf_we, fwd_valid, cond_true, cond_ok;
  logic [3:0] rf_waddr, fwd_reg, cond;
  logic [15:0] rf_wdata, fwd_data, retired;
  logic [4:0] psr_wdata, psr;
  int total = 0, bad = 0;
  alu_commit_psr_if #(.DATA_W(16), .REG_AW(4)) bus ();
  alu_commit_psr #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stall(stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .psr_we(psr_we), .psr_wdata(psr_wdata), .psr(psr),
    .cond(cond), .cond_true(cond_true), .cond_ok(cond_ok), .retired(retired));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] ext, input logic [3:0] rd,
                       input logic wb, input logic [15:0] res, input logic [4:0] fl);
    bus.in_valid = v; bus.in_opcode = op; bus.in_opext = ext; bus.in_rdest = rd;
    bus.in_wb_en = wb; bus.in_result = res; bus.in_clfzn = fl;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1; stall = 0; psr_we = 0; psr_wdata = 0; cond = 0;
    drive(1, 4'b0000, 4'b0101, 4'd3, 1, 16'h0001, 5'b10100);
    tick(); tick();
    chk("rst_psr", psr, 0);
    chk("rst_retired", retired, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cond_ok", cond_ok, 1);
    chk("rst_fwd_valid", fwd_valid, 0);
    reset = 0; bus.in_valid = 0;
    tick();
    // ADD r3
    drive(1, 4'b0000, 4'b0101, 4'd3, 1, 16'h0001, 5'b10100);
    tick();
    bus.in_valid = 0; #1;
    chk("add_rf_we", rf_we, 1);
    chk("add_waddr", rf_waddr, 3);
    chk("add_wdata", rf_wdata, 16'h0001);
    chk("add_cond_ok", cond_ok, 0);
    chk("add_psr_before", psr, 0);
    tick();
    chk("add_psr", psr, 5'b10100);
    chk("add_retired", retired, 1);
    chk("add_rf_we_after", rf_we, 0);
    // CMP keeps C,F
    drive(1, 4'b0011, 4'b0000, 4'd0, 0, 16'h0000, 5'b01011);
    tick();
    bus.in_valid = 0; #1;
    chk("cmp_cond_ok", cond_ok, 0);
    chk("cmp_fwd_valid", fwd_valid, 0);
    chk("cmp_rf_we", rf_we, 0);
    tick();
    chk("cmp_psr", psr, 5'b11111);
    chk("cmp_retired", retired, 2);
    chk("cmp_cond_ok_after", cond_ok, 1);
    cond = 4'd0; #1; chk("cc_eq", cond_true, 1);
    cond = 4'd12; #1; chk("cc_lt", cond_true, 0);
    cond = 4'd13; #1; chk("cc_ge", cond_true, 1);
    cond = 4'd15; #1; chk("cc_never", cond_true, 0);
    cond = 4'd10; #1; chk("cc_lo", cond_true, 0);
    // AND held under stall while the next instruction waits
    drive(1, 4'b1000, 4'b0000, 4'd5, 1, 16'hA5A5, 5'b00000);
    tick();
    stall = 1;
    drive(1, 4'b0001, 4'b0000, 4'd6, 1, 16'h1234, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_rf_we", rf_we, 0);
      chk("stall_fwd_valid", fwd_valid, 1);
      chk("stall_fwd_data", fwd_data, 16'hA5A5);
      chk("stall_fwd_reg", fwd_reg, 5);
      tick();
    end
    chk("stall_retired", retired, 2);
    stall = 0; #1;
    chk("rel_rf_we", rf_we, 1);
    chk("rel_waddr", rf_waddr, 5);
    chk("rel_wdata", rf_wdata, 16'hA5A5);
    chk("rel_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 0; #1;
    chk("next_retired", retired, 3);
    chk("next_rf_we", rf_we, 1);
    chk("next_waddr", rf_waddr, 6);
    chk("next_wdata", rf_wdata, 16'h1234);
    tick();
    chk("next2_retired", retired, 4);
    chk("next2_rf_we", rf_we, 0);
    chk("and_psr", psr, 5'b11111);
    // software PSR load on the ADDU commit edge
    drive(1, 4'b0000, 4'b0110, 4'd7, 1, 16'h0BEE, 5'b10100);
    tick();
    bus.in_valid = 0; psr_we = 1; psr_wdata = 5'b00001; #1;
    chk("lpr_rf_we", rf_we, 1);
    chk("lpr_wdata", rf_wdata, 16'h0BEE);
    tick();
    psr_we = 0;
    chk("lpr_psr", psr, 5'b00001);
    chk("lpr_retired", retired, 5);
    // ADDI ignores opext and touches only C,F
    drive(1, 4'b0101, 4'b1010, 4'd1, 1, 16'h0002, 5'b10000);
    tick();
    bus.in_valid = 0;
    tick();
    chk("addi_psr", psr, 5'b10001);
    // opcode 0000 with a non-arithmetic extension leaves PSR alone
    drive(1, 4'b0000, 4'b0001, 4'd1, 1, 16'h0003, 5'b01110);
    tick();
    bus.in_valid = 0;
    tick();
    chk("rr_other_psr", psr, 5'b10001);
    // reset while an instruction is held discards it
    drive(1, 4'b0101, 4'b0000, 4'd9, 1, 16'h9999, 5'b10100);
    tick();
    stall = 1; reset = 1;
    tick();
    reset = 0; stall = 0; bus.in_valid = 0; #1;
    chk("rst_stall_rf_we", rf_we, 0);
    chk("rst_stall_fwd", fwd_valid, 0);
    chk("rst_stall_retired", retired, 0);
    chk("rst_stall_psr", psr, 0);
    // retired counter wrap
    drive(1, 4'b1111, 4'b0000, 4'd0, 0, 16'h0000, 5'b00000);
    repeat (65536) tick();
    chk("wrap_max", retired, 16'hFFFF);
    tick();
    chk("wrap_zero", retired, 16'h0000);
    bus.in_valid = 0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
